// File: rtl/rmii_rx.sv
// RMII receive path: preamble/SFD hunt, dibit-to-byte assembly, CRC-32 residue check,
// and per-frame status (length, CRC, error) presented on a one-cycle rx_eof strobe.
module rmii_rx #(
    parameter int unsigned MIN_PRE = 4,
    parameter int unsigned MAX_LEN = 1522,
    parameter int unsigned MIN_LEN = 64
) (
    input  logic        clk_50MHz,
    input  logic        rst_n,
    input  logic        CRS_DV,
    input  logic        RX0,
    input  logic        RX1,
    input  logic        RX_ER,
    output logic [7:0]  rx_data,
    output logic        rx_valid,
    output logic        rx_sof,
    output logic        rx_eof,
    output logic        rx_crc_ok,
    output logic        rx_err,
    output logic [10:0] rx_len
);

    localparam int unsigned PRE_W = $clog2(MIN_PRE + 2);
    localparam logic [PRE_W-1:0] MIN_PRE_C = PRE_W'(MIN_PRE);
    localparam logic [10:0] MAX_LEN_C = 11'(MAX_LEN);
    localparam logic [10:0] MIN_LEN_C = 11'(MIN_LEN);
    localparam logic [10:0] LEN_SAT = 11'h7FF;
    localparam logic [31:0] CRC_POLY = 32'hEDB8_8320;
    localparam logic [31:0] CRC_INIT = 32'hFFFF_FFFF;
    localparam logic [31:0] CRC_RESIDUE = 32'hDEBB_20E3;

    typedef enum logic [1:0] {
        StIdle,
        StPre,
        StData,
        StDrop
    } state_e;

    state_e           state_q, state_d;
    logic [PRE_W-1:0] pre_cnt_q, pre_cnt_d;
    logic [1:0]       idx_q, idx_d;
    logic [5:0]       sr_q, sr_d;
    logic [31:0]      crc_q, crc_d;
    logic [10:0]      len_q, len_d;
    logic             err_flag_q, err_flag_d;
    logic             drop_eof_q, drop_eof_d;
    logic             low_cnt_q, low_cnt_d;
    logic             quiet_q, quiet_d;
    logic [7:0]       data_q, data_d;
    logic             valid_q, valid_d;
    logic             sof_q, sof_d;
    logic             eof_q, eof_d;
    logic             crc_ok_q, crc_ok_d;
    logic             err_q, err_d;
    logic [10:0]      len_out_q, len_out_d;

    logic [1:0]  dibit;
    logic [7:0]  byte_full;
    logic [10:0] len_inc;

    function automatic logic [31:0] crc_byte(input logic [31:0] crc, input logic [7:0] b);
        logic [31:0] c;
        c = crc ^ {24'h0, b};
        for (int i = 0; i < 8; i++) begin
            c = c[0] ? ((c >> 1) ^ CRC_POLY) : (c >> 1);
        end
        return c;
    endfunction

    assign dibit     = {RX1, RX0};
    assign byte_full = {dibit, sr_q};
    assign len_inc   = (len_q == LEN_SAT) ? len_q : len_q + 11'd1;

    always_comb begin
        state_d    = state_q;
        pre_cnt_d  = pre_cnt_q;
        idx_d      = idx_q;
        sr_d       = sr_q;
        crc_d      = crc_q;
        len_d      = len_q;
        err_flag_d = err_flag_q;
        drop_eof_d = drop_eof_q;
        low_cnt_d  = low_cnt_q;
        quiet_d    = quiet_q | ~CRS_DV;
        data_d     = data_q;
        valid_d    = 1'b0;
        sof_d      = 1'b0;
        eof_d      = 1'b0;
        crc_ok_d   = crc_ok_q;
        err_d      = err_q;
        len_out_d  = len_out_q;

        unique case (state_q)
            StIdle: begin
                // Carrier already up since reset: mid-frame, so sit it out in DROP.
                if (CRS_DV && !quiet_q) begin
                    state_d    = StDrop;
                    drop_eof_d = 1'b0;
                    low_cnt_d  = 1'b0;
                end else if (CRS_DV && dibit == 2'b01) begin
                    state_d   = StPre;
                    pre_cnt_d = PRE_W'(1);
                end
            end

            StPre: begin
                if (!CRS_DV) begin
                    state_d = StIdle;
                end else begin
                    case (dibit)
                        2'b01: begin
                            if (pre_cnt_q < MIN_PRE_C) begin
                                pre_cnt_d = pre_cnt_q + PRE_W'(1);
                            end
                        end
                        2'b11: begin
                            if (pre_cnt_q >= MIN_PRE_C) begin
                                state_d    = StData;
                                idx_d      = 2'd0;
                                sr_d       = 6'd0;
                                len_d      = 11'd0;
                                crc_d      = CRC_INIT;
                                err_flag_d = 1'b0;
                            end else begin
                                state_d    = StDrop;
                                drop_eof_d = 1'b0;
                                low_cnt_d  = 1'b0;
                            end
                        end
                        default: begin
                            state_d    = StDrop;
                            drop_eof_d = 1'b0;
                            low_cnt_d  = 1'b0;
                        end
                    endcase
                end
            end

            StData: begin
                err_flag_d = err_flag_q | RX_ER;
                if (!CRS_DV && idx_q == 2'd0) begin
                    state_d   = StIdle;
                    eof_d     = 1'b1;
                    crc_ok_d  = (crc_q == CRC_RESIDUE);
                    len_out_d = len_q;
                    err_d     = err_flag_q | RX_ER | (len_q < MIN_LEN_C) | (len_q > MAX_LEN_C);
                end else if (!CRS_DV && idx_q[0]) begin
                    // Carrier lost mid-nibble: byte alignment is unrecoverable.
                    state_d    = StDrop;
                    drop_eof_d = 1'b1;
                    low_cnt_d  = 1'b0;
                    err_flag_d = 1'b1;
                end else begin
                    // CRS_DV low at index 2 is the PHY's carrier-drop toggle; data is still valid.
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        crc_d = crc_byte(crc_q, byte_full);
                        len_d = len_inc;
                        if (len_q >= MAX_LEN_C) begin
                            state_d    = StDrop;
                            drop_eof_d = 1'b1;
                            low_cnt_d  = 1'b0;
                            err_flag_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            data_d  = byte_full;
                            sof_d   = (len_q == 11'd0);
                        end
                    end else begin
                        sr_d = {dibit, sr_q[5:2]};
                    end
                end
            end

            StDrop: begin
                if (CRS_DV) begin
                    low_cnt_d = 1'b0;
                end else if (low_cnt_q) begin
                    state_d    = StIdle;
                    low_cnt_d  = 1'b0;
                    drop_eof_d = 1'b0;
                    if (drop_eof_q) begin
                        eof_d     = 1'b1;
                        err_d     = 1'b1;
                        crc_ok_d  = 1'b0;
                        len_out_d = len_q;
                    end
                end else begin
                    low_cnt_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk_50MHz or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            pre_cnt_q  <= '0;
            idx_q      <= 2'd0;
            sr_q       <= 6'd0;
            crc_q      <= CRC_INIT;
            len_q      <= 11'd0;
            err_flag_q <= 1'b0;
            drop_eof_q <= 1'b0;
            low_cnt_q  <= 1'b0;
            quiet_q    <= 1'b0;
            data_q     <= 8'h00;
            valid_q    <= 1'b0;
            sof_q      <= 1'b0;
            eof_q      <= 1'b0;
            crc_ok_q   <= 1'b0;
            err_q      <= 1'b0;
            len_out_q  <= 11'd0;
        end else begin
            state_q    <= state_d;
            pre_cnt_q  <= pre_cnt_d;
            idx_q      <= idx_d;
            sr_q       <= sr_d;
            crc_q      <= crc_d;
            len_q      <= len_d;
            err_flag_q <= err_flag_d;
            drop_eof_q <= drop_eof_d;
            low_cnt_q  <= low_cnt_d;
            quiet_q    <= quiet_d;
            data_q     <= data_d;
            valid_q    <= valid_d;
            sof_q      <= sof_d;
            eof_q      <= eof_d;
            crc_ok_q   <= crc_ok_d;
            err_q      <= err_d;
            len_out_q  <= len_out_d;
        end
    end

    assign rx_data   = data_q;
    assign rx_valid  = valid_q;
    assign rx_sof    = sof_q;
    assign rx_eof    = eof_q;
    assign rx_crc_ok = crc_ok_q;
    assign rx_err    = err_q;
    assign rx_len    = len_out_q;

endmodule

// File: doc/rmii_rx.md
RMII_RX -- requirements
Module: rmii_rx

Interface
REQ-001 SHALL provide parameter MIN_PRE, default 4, minimum count of 01 preamble dibits required before the SFD dibit.
REQ-002 SHALL provide parameter MAX_LEN, default 1522, maximum accepted frame length in bytes, FCS included.
REQ-003 SHALL provide parameter MIN_LEN, default 64, minimum accepted frame length in bytes, FCS included.
REQ-004 SHALL have port clk_50MHz  input  1  single RMII reference clock; all logic on rising edge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port CRS_DV  input  1  PHY carrier-sense/data-valid.
REQ-007 SHALL have ports RX0, RX1  input  1 each  receive dibit; RX0 is the lower bit.
REQ-008 SHALL have port RX_ER  input  1  PHY receive error.
REQ-009 SHALL have port rx_data  output  8  assembled byte.
REQ-010 SHALL have port rx_valid  output  1  one-cycle strobe; rx_data is valid.
REQ-011 SHALL have port rx_sof  output  1  asserted with rx_valid on the first byte after the SFD.
REQ-012 SHALL have port rx_eof  output  1  one-cycle frame-end strobe; status outputs are valid.
REQ-013 SHALL have ports rx_crc_ok, rx_err, rx_len[10:0]  output  status; held from one rx_eof until the next.

Function
REQ-014 SHALL sample CRS_DV, RX1:RX0 and RX_ER once per clk_50MHz cycle (100 Mb/s, one dibit per cycle).
REQ-015 SHALL implement FSM IDLE, PRE, DATA, DROP.
REQ-016 IDLE: SHALL go to PRE on CRS_DV=1 with dibit 01, counting that dibit; otherwise SHALL stay in IDLE.
REQ-017 PRE: SHALL count 01 dibits while CRS_DV=1.
REQ-018 PRE: SHALL go to DATA on dibit 11 when the count is at least MIN_PRE.
REQ-019 PRE: SHALL go to DROP on dibit 11 with the count below MIN_PRE, or on dibit 00 or 10.
REQ-020 PRE: SHALL go to IDLE on CRS_DV=0, with no rx_eof.
REQ-021 DATA: SHALL assemble bytes LSB-first; dibit k (k=0..3) fills rx_data[2k+1:2k].
REQ-022 SHALL assert rx_valid exactly one cycle after the 4th dibit of a byte is sampled.
REQ-023 CRS_DV=0 at dibit index 0 SHALL end the frame.
REQ-024 CRS_DV=0 at dibit index 2 SHALL be treated as a carrier-drop toggle; the dibit SHALL be accepted as data.
REQ-025 CRS_DV=0 at dibit index 1 or 3 SHALL set the alignment error flag and SHALL go to DROP.
REQ-026 SHALL compute reflected CRC-32 (poly 0xEDB88320, init 0xFFFFFFFF) over every byte after the SFD, FCS included.
REQ-027 rx_crc_ok SHALL be 1 only when the final register equals residue 0xDEBB20E3.
REQ-028 rx_len SHALL count bytes after the SFD, FCS included.
REQ-029 rx_len SHALL saturate at 2047.
REQ-030 At frame end SHALL pulse rx_eof one cycle after the terminating sample and SHALL go to IDLE.
REQ-031 rx_err SHALL be 1 if RX_ER was seen in DATA, or on alignment error, or rx_len < MIN_LEN, or rx_len > MAX_LEN.
REQ-032 On byte count exceeding MAX_LEN, rx_valid SHALL stop and the FSM SHALL go to DROP.
REQ-033 DROP: SHALL emit no rx_valid.
REQ-034 DROP: SHALL go to IDLE after CRS_DV=0 for 2 consecutive cycles.
REQ-035 DROP: SHALL pulse rx_eof with rx_err=1 only if DROP was entered from DATA.
REQ-036 RX_ER in DATA SHALL latch the error flag while reception continues, so rx_len stays accurate.
REQ-037 RX_ER and frame end in the same cycle SHALL report rx_err=1.
REQ-038 rx_valid and rx_eof SHALL never be asserted in the same cycle.
REQ-039 rx_eof SHALL follow the last rx_valid by at least one cycle.

Reset
REQ-040 While rst_n=0, SHALL be in IDLE with rx_data=0x00 and rx_valid=0.
REQ-041 While rst_n=0, SHALL hold rx_sof=0, rx_eof=0, rx_crc_ok=0, rx_err=0, rx_len=0.
REQ-042 While rst_n=0, the CRC register SHALL be 0xFFFFFFFF and all counters SHALL be 0.
REQ-043 Reset asserted mid-frame SHALL abort the frame with no rx_eof.
REQ-044 After reset release, the first frame SHALL be accepted only from a fresh preamble.
REQ-045 After reset release with CRS_DV already high, SHALL wait in DROP for CRS_DV low.

Verification
REQ-046 Scenario: 7x 0x55 preamble + 0xD5 SFD + 60 payload bytes + correct FCS -> 64 rx_valid, rx_sof on byte 1, rx_eof with rx_crc_ok=1, rx_err=0, rx_len=64.
REQ-047 Scenario: same frame with payload byte 10 flipped 0xAA->0xAB -> rx_crc_ok=0, rx_err=0, rx_len=64.
REQ-048 Scenario: RX_ER high 1 cycle at byte 20 -> all 64 bytes delivered, rx_err=1, rx_len=64.
REQ-049 Scenario: 1600-byte frame -> exactly 1522 rx_valid, then rx_eof with rx_err=1 after CRS_DV falls.
REQ-050 Scenario: 40-byte runt with valid FCS -> rx_crc_ok=1, rx_err=1, rx_len=40.
REQ-051 Scenario: rst_n low at byte 30, then a valid 64-byte frame -> no rx_eof for the aborted frame; second frame reports rx_crc_ok=1, rx_len=64.
